fft_frame_scheduler: RTL

Sequences the audio-to-note datapath. It takes AC97 samples on the `ready` strobe, decimates them, and buffers them in a small FIFO. It streams fixed-length frames into the FFT core, then triggers the note-identification scan and latches its 4-bit result. The block sits between the AC97 interface and the FFT/note-identification pair and is the only module that starts either of them.

---
 rtl/fft_frame_scheduler_if.sv | 26 ++
 rtl/fft_frame_scheduler.sv | 118 +++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: signal bundle between the scheduler and the AC97/FFT/note-id blocks
interface fft_frame_scheduler_if;
  logic        enable;
  logic        ready;
  logic [15:0] from_ac97_data;
  logic [15:0] fft_din;
  logic        fft_din_valid;
  logic        fft_frame_first;
  logic        fft_rfd;
  logic        fft_done;
  logic        id_start;
  logic        id_done;
  logic [3:0]  id_note;
  logic [3:0]  note;
  logic        note_valid;
  logic [7:0]  drop_count;
  logic        timeout_err;
  modport master (
    input  enable, ready, from_ac97_data, fft_rfd, fft_done, id_done, id_note,
    output fft_din, fft_din_valid, fft_frame_first, id_start, note, note_valid, drop_count, timeout_err
  );
  modport slave (
    output enable, ready, from_ac97_data, fft_rfd, fft_done, id_done, id_note,
    input  fft_din, fft_din_valid, fft_frame_first, id_start, note, note_valid, drop_count, timeout_err
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: decimates AC97 samples into FFT frames and sequences the note-id scan
module fft_frame_scheduler #(
  parameter int FRAME_LEN  = 1024,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input logic                   clk,
  input logic                   reset_n,
  fft_frame_scheduler_if.master bus
);
  localparam int PW = $clog2(FRAME_LEN + 1);
  localparam int DW = $clog2(DECIM + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] FLEN  = PW'(FRAME_LEN);
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, WAIT_FFT = 2'd2, IDENT = 2'd3;
  logic [1:0]    state, nxt, resume;
  logic          ready_d;
  logic [PW-1:0] push_cnt;
  logic [DW-1:0] decim_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [16:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   fft_din_q;
  logic          fft_din_valid_q, fft_frame_first_q, id_start_q, note_valid_q, timeout_err_q;
  logic [3:0]    note_q, id_buf;
  logic          id_pend;
  logic [7:0]    drop_q;
  logic          rise, fill, flush, frame_done, take, full, pop, push, drop, wait_st, done_here, tmo_fire;
  assign rise       = bus.ready && !ready_d;
  assign fill       = state == FILL;
  assign flush      = fill && !bus.enable;
  assign frame_done = push_cnt == FLEN;
  assign take       = fill && bus.enable && rise && decim_cnt == '0 && !frame_done;
  assign full       = count == DEPTH;
  assign pop        = bus.fft_rfd && count != '0 && !flush;
  assign push       = take && (!full || pop);
  assign drop       = take && full && !pop;
  assign wait_st    = state[1];
  assign done_here  = (state == WAIT_FFT && bus.fft_done) || (state == IDENT && bus.id_done);
  assign tmo_fire   = wait_st && !done_here && tmo_cnt == TLAST;
  assign resume     = bus.enable ? FILL : IDLE;
  assign head       = mem[rd_ptr];
  // next state: a wait state is left on its done pulse or on timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = bus.enable ? FILL : IDLE;
      FILL:     nxt = !bus.enable ? IDLE : (frame_done && count == '0) ? WAIT_FFT : FILL;
      WAIT_FFT: nxt = bus.fft_done ? IDENT : tmo_fire ? resume : WAIT_FFT;
      default:  nxt = (bus.id_done || tmo_fire) ? resume : IDENT;
    endcase
  end
  // control state, decimation, frame counting and FIFO pointers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      ready_d   <= 1'b1;
      push_cnt  <= '0;
      decim_cnt <= '0;
      tmo_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= nxt;
      ready_d   <= bus.ready;
      push_cnt  <= fill ? push_cnt + PW'(push) : '0;
      decim_cnt <= (state == IDLE) ? '0 : (fill && bus.enable && rise) ? (decim_cnt == DLAST ? '0 : decim_cnt + DW'(1)) : decim_cnt;
      tmo_cnt   <= (wait_st && nxt == state) ? tmo_cnt + TW'(1) : '0;
      wr_ptr    <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr    <= flush ? '0 : rd_ptr + AW'(pop);
      count     <= flush ? '0 : count + CW'(push) - CW'(pop);
    end
  // sample storage; the top bit tags sample 0 of a frame
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {push_cnt == '0, bus.from_ac97_data};
  // registered outputs; the note result is staged one cycle before publishing
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fft_din_q         <= '0;
      fft_din_valid_q   <= 1'b0;
      fft_frame_first_q <= 1'b0;
      id_start_q        <= 1'b0;
      id_pend           <= 1'b0;
      id_buf            <= '0;
      note_q            <= '0;
      note_valid_q      <= 1'b0;
      drop_q            <= '0;
      timeout_err_q     <= 1'b0;
    end else begin
      fft_din_q         <= pop ? head[15:0] : fft_din_q;
      fft_din_valid_q   <= pop;
      fft_frame_first_q <= pop && head[16];
      id_start_q        <= state == WAIT_FFT && bus.fft_done;
      id_pend           <= state == IDENT && bus.id_done;
      id_buf            <= (state == IDENT && bus.id_done) ? bus.id_note : id_buf;
      note_q            <= id_pend ? id_buf : note_q;
      note_valid_q      <= id_pend;
      drop_q            <= (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      timeout_err_q     <= timeout_err_q || tmo_fire;
    end
  assign bus.fft_din         = fft_din_q;
  assign bus.fft_din_valid   = fft_din_valid_q;
  assign bus.fft_frame_first = fft_frame_first_q;
  assign bus.id_start        = id_start_q;
  assign bus.note            = note_q;
  assign bus.note_valid      = note_valid_q;
  assign bus.drop_count      = drop_q;
  assign bus.timeout_err     = timeout_err_q;
endmodule
